// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: frame states, parity modes
// and the default baud divisor for a 10 MHz sysclk at 115200 baud.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int SYSCLK_HZ = 10_000_000;
  localparam int BAUD_RATE = 115_200;
  // Rounded to nearest: 10e6 / 115200 = 86.8 -> 87
  localparam int DEFAULT_CLKS_PER_BIT = (SYSCLK_HZ + BAUD_RATE / 2) / BAUD_RATE;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-facing bus of the buffered UART transmitter: write port, overflow clear,
// status flags and the serial line itself.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);

  logic                          wr_en;
  logic [DATA_BITS-1:0]          wr_data;
  logic                          ovf_clr;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          busy;
  logic                          ovf;
  logic                          uart_tx;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  full, empty, count, busy, ovf, uart_tx
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output full, empty, count, busy, ovf, uart_tx
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered level flags; the head word is visible before the
// pop edge so the consumer can capture it on the same edge it pops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO still lands when the head leaves on the same edge
  assign do_pop  = pop && !empty_reg;
  assign do_push = push && (!full_reg || do_pop);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_LVL);
      empty_reg <= (count_next == '0);
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign full      = full_reg;
  assign empty     = empty_reg;
  assign count     = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: CPU words queue in a FIFO and a frame FSM serialises
// them LSB-first with optional parity and one or two stop bits.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           sysclk,
  input  logic           cpu_resetn,
  uart_tx_fifo_if.slave  bus
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter combination");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  state_t               state_reg;
  logic [CW-1:0]        tick_reg;
  logic [IW-1:0]        idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_reg;
  logic                 tx_reg;
  logic                 busy_reg;
  logic                 ovf_reg;

  logic [DATA_BITS-1:0] head_data;
  logic                 bit_end;
  logic                 frame_end;
  logic                 pop;
  logic                 drop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sysclk),
    .rst_n     (cpu_resetn),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (bus.full),
    .empty     (bus.empty),
    .count     (bus.count)
  );

  assign bit_end   = (tick_reg == LAST_TICK);
  assign frame_end = (state_reg == ST_STOP) && bit_end && (idx_reg == LAST_STOP);
  // Popping on the last stop edge chains frames with no idle gap
  assign pop       = !bus.empty && ((state_reg == ST_IDLE) || frame_end);
  assign drop      = bus.wr_en && bus.full && !pop;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      tick_reg <= (state_reg == ST_IDLE || bit_end) ? '0 : tick_reg + 1'b1;
      if (pop) begin
        shift_reg <= head_data;
        par_reg   <= (^head_data) ^ (PARITY == PAR_ODD);
        idx_reg   <= '0;
        state_reg <= ST_START;
        tx_reg    <= 1'b0;
        busy_reg  <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
          end
          ST_START: begin
            if (bit_end) begin
              state_reg <= ST_DATA;
              idx_reg   <= '0;
              tx_reg    <= shift_reg[0];
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              if (idx_reg == LAST_DATA) begin
                idx_reg <= '0;
                if (PARITY != PAR_NONE) begin
                  state_reg <= ST_PAR;
                  tx_reg    <= par_reg;
                end else begin
                  state_reg <= ST_STOP;
                  tx_reg    <= 1'b1;
                end
              end else begin
                idx_reg   <= idx_reg + 1'b1;
                shift_reg <= shift_reg >> 1;
                tx_reg    <= shift_reg[1];
              end
            end
          end
          ST_PAR: begin
            if (bit_end) begin
              state_reg <= ST_STOP;
              idx_reg   <= '0;
              tx_reg    <= 1'b1;
            end
          end
          ST_STOP: begin
            if (bit_end) begin
              if (idx_reg == LAST_STOP) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
                tx_reg    <= 1'b1;
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A dropped write outranks a simultaneous clear so no overflow goes unreported
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign bus.uart_tx = tx_reg;
  assign bus.busy    = busy_reg;
  assign bus.ovf     = ovf_reg;

endmodule
